// File: rtl/axi4s_uart_pkg.sv
// Shared definitions for the axi4s_uart transmitter/receiver pair.
package axi4s_uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  // aclk cycles per line bit, truncated.
  function automatic int unsigned tics_per_beat(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability chain for the asynchronous RX pin plus falling-edge detect.
module uart_rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rxd,
  output logic rxd_s,
  output logic fall
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_stages_check
    $error("SYNC_STAGES must be in 2..4");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset to the idle (high) level so leaving reset never fakes an edge on an idle line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];
  assign fall  = prev_q & ~rxd_s;

endmodule

// File: rtl/axi4s_uart_rx.sv
// 8N1 UART receiver delivering each good byte as a single-beat AXI4-Stream transfer.
module axi4s_uart_rx
  import axi4s_uart_pkg::*;
#(
  parameter int unsigned ACLK_FREQUENCY = 200000000,
  parameter int unsigned BAUD_RATE      = 9600,
  parameter int unsigned BAUD_RATE_SIM  = 50000000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       aclk,
  input  logic       areset,
  input  logic       uart_rxd,
  output logic       rxbyte_tvalid,
  input  logic       rxbyte_tready,
  output logic [7:0] rxbyte_tdata,
  output logic       rxbyte_tkeep,
  output logic       frame_error,
  output logic       overrun
);

`ifdef SYNTHESIS
  localparam bit UseSimBaud = 1'b0;
`else
  localparam bit UseSimBaud = 1'b1;
`endif

  localparam int unsigned USED_BAUD_RATE = UseSimBaud ? BAUD_RATE_SIM : BAUD_RATE;
  localparam int unsigned TPB            = tics_per_beat(ACLK_FREQUENCY, USED_BAUD_RATE);
  localparam int unsigned HALF           = TPB / 2;
  localparam int unsigned TW             = $clog2(TPB);
  localparam int unsigned BW             = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TicFull = TW'(TPB - 1);
  localparam logic [TW-1:0] TicHalf = TW'(HALF - 1);
  localparam logic [BW-1:0] BitLast = BW'(DATA_BITS - 1);

  if (TPB < 4) begin : g_tpb_check
    $error("ACLK_FREQUENCY/baud must give at least 4 cycles per bit");
  end

  logic rxd_s;
  logic fall;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (aclk),
    .rst  (areset),
    .rxd  (uart_rxd),
    .rxd_s(rxd_s),
    .fall (fall)
  );

  uart_rx_state_t       state_q, state_d;
  logic [TW-1:0]        tic_q, tic_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 deliver;
  logic                 frame_err_d;
  logic                 tic_zero;

  assign tic_zero = (tic_q == '0);

  always_comb begin
    state_d     = state_q;
    tic_d       = tic_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    deliver     = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          tic_d   = TicHalf;
          state_d = START;
        end
      end
      START: begin
        if (!tic_zero) begin
          tic_d = tic_q - 1'b1;
        end else if (!rxd_s) begin
          tic_d   = TicFull;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!tic_zero) begin
          tic_d = tic_q - 1'b1;
        end else begin
          shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          tic_d   = TicFull;
          if (bit_q == BitLast) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (!tic_zero) begin
          tic_d = tic_q - 1'b1;
        end else begin
          state_d     = IDLE;
          deliver     = rxd_s;
          frame_err_d = ~rxd_s;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      tic_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      tic_q   <= tic_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  logic       tvalid_q, tvalid_d;
  logic [7:0] tdata_q, tdata_d;
  logic       frame_err_q;
  logic       overrun_q, overrun_d;

  // A byte completing in the same cycle as a handshake replaces the consumed one.
  always_comb begin
    tvalid_d  = tvalid_q;
    tdata_d   = tdata_q;
    overrun_d = 1'b0;
    if (tvalid_q && rxbyte_tready) begin
      tvalid_d = 1'b0;
    end
    if (deliver) begin
      if (!tvalid_q || rxbyte_tready) begin
        tvalid_d = 1'b1;
        tdata_d  = shift_q;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rxbyte_tvalid = tvalid_q;
  assign rxbyte_tdata  = tdata_q;
  assign rxbyte_tkeep  = 1'b1;
  assign frame_error   = frame_err_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_axi4s_uart_rx.sv
// Directed bench for axi4s_uart_rx at 100 MHz aclk and 10 Mbaud (10 cycles per bit).
module tb_axi4s_uart_rx;

  localparam int ClkHalf = 5;
  localparam int BitNs   = 100;

  logic       aclk = 1'b0;
  logic       areset;
  logic       uart_rxd;
  logic       rxbyte_tvalid;
  logic       rxbyte_tready;
  logic [7:0] rxbyte_tdata;
  logic       rxbyte_tkeep;
  logic       frame_error;
  logic       overrun;

  int         total = 0;
  int         bad = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  logic [7:0] rx_q[$];

  always #ClkHalf aclk = ~aclk;

  axi4s_uart_rx #(
    .ACLK_FREQUENCY(100000000),
    .BAUD_RATE     (10000000),
    .BAUD_RATE_SIM (10000000),
    .SYNC_STAGES   (2)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .uart_rxd     (uart_rxd),
    .rxbyte_tvalid(rxbyte_tvalid),
    .rxbyte_tready(rxbyte_tready),
    .rxbyte_tdata (rxbyte_tdata),
    .rxbyte_tkeep (rxbyte_tkeep),
    .frame_error  (frame_error),
    .overrun      (overrun)
  );

  // Accepted beats and error pulses, sampled mid-cycle.
  always @(negedge aclk) begin
    if (rxbyte_tvalid && rxbyte_tready) rx_q.push_back(rxbyte_tdata);
    if (frame_error) fe_cnt++;
    if (overrun) ov_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] byte_at(input int idx);
    if (idx < rx_q.size()) return {24'h0, rx_q[idx]};
    return 32'hdead;
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int bit_t);
    uart_rxd = 1'b0;
    #(bit_t);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      #(bit_t);
    end
    uart_rxd = stop_bit;
    #(bit_t);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #2;
  endtask

  initial begin
    int b0;
    int f0;
    int o0;
    logic [7:0] pat;

    areset        = 1'b1;
    uart_rxd      = 1'b1;
    rxbyte_tready = 1'b1;
    repeat (4) @(negedge aclk);
    check_val("rst_tvalid", rxbyte_tvalid, 0);
    check_val("rst_tdata", rxbyte_tdata, 0);
    check_val("rst_frame_error", frame_error, 0);
    check_val("rst_overrun", overrun, 0);
    areset = 1'b0;
    idle(5);

    // Single byte
    b0 = rx_q.size(); f0 = fe_cnt; o0 = ov_cnt;
    send_byte(8'hA5, 1'b1, BitNs);
    idle(20);
    check_val("t1_count", rx_q.size() - b0, 1);
    check_val("t1_data", byte_at(b0), 32'hA5);
    check_val("t1_tkeep", rxbyte_tkeep, 1);
    check_val("t1_fe", fe_cnt - f0, 0);
    check_val("t1_ov", ov_cnt - o0, 0);

    // Back-to-back frames
    b0 = rx_q.size();
    send_byte(8'h00, 1'b1, BitNs);
    send_byte(8'hFF, 1'b1, BitNs);
    idle(20);
    check_val("t2_count", rx_q.size() - b0, 2);
    check_val("t2_first", byte_at(b0), 32'h00);
    check_val("t2_second", byte_at(b0 + 1), 32'hFF);

    // Short low glitch is rejected at the start-bit sample
    b0 = rx_q.size(); f0 = fe_cnt;
    uart_rxd = 1'b0;
    repeat (3) @(posedge aclk);
    uart_rxd = 1'b1;
    idle(30);
    check_val("t3_glitch_count", rx_q.size() - b0, 0);
    check_val("t3_glitch_fe", fe_cnt - f0, 0);
    send_byte(8'h3C, 1'b1, BitNs);
    idle(20);
    check_val("t3_count", rx_q.size() - b0, 1);
    check_val("t3_data", byte_at(b0), 32'h3C);

    // Framing error followed by a held-low break
    b0 = rx_q.size(); f0 = fe_cnt; o0 = ov_cnt;
    send_byte(8'h55, 1'b0, BitNs);
    #(50 * 2 * ClkHalf);
    uart_rxd = 1'b1;
    idle(30);
    check_val("t4_fe", fe_cnt - f0, 1);
    check_val("t4_count", rx_q.size() - b0, 0);
    check_val("t4_ov", ov_cnt - o0, 0);

    // Backpressure and overrun
    @(posedge aclk); #2;
    rxbyte_tready = 1'b0;
    b0 = rx_q.size(); o0 = ov_cnt;
    send_byte(8'h11, 1'b1, BitNs);
    send_byte(8'h22, 1'b1, BitNs);
    idle(20);
    check_val("t5_tvalid_held", rxbyte_tvalid, 1);
    check_val("t5_tdata_held", rxbyte_tdata, 32'h11);
    check_val("t5_ov", ov_cnt - o0, 1);
    check_val("t5_no_accept", rx_q.size() - b0, 0);
    rxbyte_tready = 1'b1;
    idle(3);
    check_val("t5_count", rx_q.size() - b0, 1);
    check_val("t5_data", byte_at(b0), 32'h11);
    check_val("t5_tvalid_drop", rxbyte_tvalid, 0);

    // Reset in the middle of 0x81
    b0 = rx_q.size();
    pat = 8'h81;
    uart_rxd = 1'b0;
    #(BitNs);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = pat[i];
      #(BitNs);
    end
    uart_rxd = pat[4];
    #(BitNs / 2);
    areset = 1'b1;
    @(negedge aclk);
    check_val("t6_rst_tvalid", rxbyte_tvalid, 0);
    check_val("t6_rst_tdata", rxbyte_tdata, 0);
    check_val("t6_rst_fe", frame_error, 0);
    check_val("t6_rst_ov", overrun, 0);
    #(3 * BitNs);
    uart_rxd = 1'b1;
    #(3 * BitNs);
    @(negedge aclk);
    areset = 1'b0;
    idle(10);
    send_byte(8'h7E, 1'b1, BitNs);
    idle(20);
    check_val("t6_count", rx_q.size() - b0, 1);
    check_val("t6_data", byte_at(b0), 32'h7E);

    // Line rate 3% fast and 3% slow
    b0 = rx_q.size(); f0 = fe_cnt;
    send_byte(8'hC3, 1'b1, 97);
    idle(10);
    send_byte(8'hC3, 1'b1, 103);
    idle(20);
    check_val("t7_count", rx_q.size() - b0, 2);
    check_val("t7_fast", byte_at(b0), 32'hC3);
    check_val("t7_slow", byte_at(b0 + 1), 32'hC3);
    check_val("t7_fe", fe_cnt - f0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
